// File: rtl/matmult_seq_ctrl.sv
// Sequencer for the 3x3 matmult datapath: loads A/B serially, waits out LAT, drains C.
// Optional perf_cycles output enabled by defining MATMULT_SEQ_CTRL_PERF_EN.
`timescale 1ns/1ps
module matmult_seq_ctrl #(
    parameter int unsigned DW  = 32,
    parameter int unsigned LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic            out_last,
    output logic [9*DW-1:0] dp_a,
    output logic [9*DW-1:0] dp_b,
    input  logic [9*DW-1:0] dp_c,
    output logic            busy,
    output logic            err
`ifdef MATMULT_SEQ_CTRL_PERF_EN
    ,
    output logic [31:0]     perf_cycles
`endif
);

    localparam int unsigned WW = $clog2(LAT + 1) + 1;

    typedef enum logic [1:0] {StLoad, StWait, StDrain} state_e;

    state_e          state_q, state_d;
    logic [4:0]      idx_q, idx_d;
    logic [WW-1:0]   wcnt_q, wcnt_d;
    logic [3:0]      ocnt_q, ocnt_d;
    logic [9*DW-1:0] a_q, a_d;
    logic [9*DW-1:0] b_q, b_d;
    logic [9*DW-1:0] res_q, res_d;
    logic            err_q, err_d;
    logic            load_hs;

    assign load_hs = in_valid && (state_q == StLoad);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wcnt_d  = wcnt_q;
        ocnt_d  = ocnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        err_d   = err_q;
        unique case (state_q)
            StLoad: begin
                if (load_hs) begin
                    if (idx_q < 5'd9) begin
                        a_d[idx_q*DW +: DW] = in_data;
                    end else begin
                        b_d[(idx_q - 5'd9)*DW +: DW] = in_data;
                    end
                    if (idx_q == 5'd17) begin
                        // Missing in_last on the final word is flagged but the job still runs.
                        if (!in_last) err_d = 1'b1;
                        state_d = StWait;
                        wcnt_d  = '0;
                        idx_d   = '0;
                    end else if (in_last) begin
                        err_d = 1'b1;
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            StWait: begin
                if (wcnt_q == WW'(LAT)) begin
                    res_d   = dp_c;
                    ocnt_d  = '0;
                    state_d = StDrain;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            StDrain: begin
                if (out_ready) begin
                    if (ocnt_q == 4'd8) state_d = StLoad;
                    else                ocnt_d  = ocnt_q + 4'd1;
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StLoad;
            idx_q   <= '0;
            wcnt_q  <= '0;
            ocnt_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
            ocnt_q  <= ocnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    // in_ready is gated by rst so every output reads 0 while reset is held.
    assign in_ready  = (state_q == StLoad) && !rst;
    assign out_valid = (state_q == StDrain);
    assign out_data  = res_q[ocnt_q*DW +: DW];
    assign out_last  = out_valid && (ocnt_q == 4'd8);
    assign busy      = (state_q != StLoad) || (idx_q != 5'd0);
    assign err       = err_q;
    assign dp_a      = a_q;
    assign dp_b      = b_q;

`ifdef MATMULT_SEQ_CTRL_PERF_EN
    logic [31:0] pcnt_q, pcnt_d, perf_q, perf_d, pinc;

    assign pinc = (pcnt_q == 32'hFFFF_FFFF) ? pcnt_q : pcnt_q + 32'd1;

    always_comb begin
        pcnt_d = pinc;
        perf_d = perf_q;
        // Counting restarts at the first word of each job; idle cycles hold it at 0.
        if (state_q == StLoad && idx_q == 5'd0) pcnt_d = load_hs ? 32'd1 : 32'd0;
        if (state_q == StDrain && out_ready && ocnt_q == 4'd8) perf_d = pinc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q <= '0;
            perf_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule
